// File: rtl/display_pkg.sv
// Shared constants, state encoding and BCD-to-segment mapping for the decimal display path.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package display_pkg;

    localparam int DIGIT_W = 4;
    localparam int SEG_W   = 7;

    // Active-low segment patterns, bit0 = a ... bit6 = g
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    // One BCD nibble to active-low gfedcba; non-decimal nibbles show nothing
    function automatic logic [SEG_W-1:0] digit_to_seg(input logic [DIGIT_W-1:0] d);
        logic [SEG_W-1:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Largest value representable in n decimal digits (10^n - 1)
    function automatic logic [63:0] max_decimal(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

endpackage

// File: rtl/decimal_decoder.sv
// Single BCD digit to active-low seven-segment pattern.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows input.
module decimal_decoder
    import display_pkg::*;
(
    input  logic [DIGIT_W-1:0] bcd,
    output logic [SEG_W-1:0]   seg
);

    assign seg = digit_to_seg(bcd);

endmodule

// File: rtl/decimal_display_seq.sv
// Binary to BCD (double-dabble, one bit per clock) driving DIGITS seven-segment outputs.
// Latency: accept at edge T, results and o_done pulse at edge T+BIN_W+1.
// Backpressure: o_ready low while converting; i_valid is ignored until o_ready returns.
module decimal_display_seq
    import display_pkg::*;
#(
    parameter int DIGITS   = 6,
    parameter int BIN_W    = 20,
    parameter int LZ_BLANK = 1
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_valid,
    input  logic [BIN_W-1:0]          i_bin,
    output logic                      o_ready,
    output logic                      o_done,
    output logic                      o_overflow,
    output logic [DIGITS*DIGIT_W-1:0] o_bcd,
    output logic [DIGITS*SEG_W-1:0]   o_seg
);

    localparam int          BCD_W   = DIGITS * DIGIT_W;
    localparam int          SEGS_W  = DIGITS * SEG_W;
    localparam int          CNT_W   = $clog2(BIN_W + 1);
    localparam logic [63:0] MAX_VAL = max_decimal(DIGITS);

    state_t             state;
    logic [BIN_W-1:0]   bin_q;
    logic [BCD_W-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_q;

    logic [BCD_W-1:0]   acc_adj;
    logic [BCD_W-1:0]   acc_next;
    logic [BIN_W-1:0]   bin_next;
    logic [SEGS_W-1:0]  dec_seg;
    logic [SEGS_W-1:0]  seg_next;
    logic               seen_nz;

    // Ready is purely a decode of state, so there is no path from i_valid
    assign o_ready = (state == ST_IDLE);

    // One double-dabble step: add 3 to nibbles >= 5, then shift {bcd, bin} left
    always_comb begin
        acc_adj = acc_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (acc_q[k*DIGIT_W +: DIGIT_W] >= 4'd5) begin
                acc_adj[k*DIGIT_W +: DIGIT_W] = acc_q[k*DIGIT_W +: DIGIT_W] + 4'd3;
            end
        end
        // Bits shifted out of the top nibble are dropped; the overflow flag covers them
        {acc_next, bin_next} = {acc_adj, bin_q} << 1;
    end

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_dec
            decimal_decoder u_dec (
                .bcd (acc_q[g*DIGIT_W +: DIGIT_W]),
                .seg (dec_seg[g*SEG_W +: SEG_W])
            );
        end
    endgenerate

    // Per-digit display pattern: dashes on overflow, optional leading-zero blanking
    always_comb begin
        seg_next = '0;
        seen_nz  = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            seen_nz = seen_nz | (acc_q[k*DIGIT_W +: DIGIT_W] != 4'd0);
            if (ovf_q) begin
                seg_next[k*SEG_W +: SEG_W] = SEG_DASH;
            end else if ((LZ_BLANK != 0) && (k != 0) && !seen_nz) begin
                // Digit 0 always shows, so a zero value reads "0"
                seg_next[k*SEG_W +: SEG_W] = SEG_BLANK;
            end else begin
                seg_next[k*SEG_W +: SEG_W] = dec_seg[k*SEG_W +: SEG_W];
            end
        end
    end

    // Control FSM, conversion datapath and output registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= ST_IDLE;
            bin_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            o_done     <= 1'b0;
            o_overflow <= 1'b0;
            o_bcd      <= '0;
            o_seg      <= {DIGITS{SEG_BLANK}};
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        bin_q <= i_bin;
                        acc_q <= '0;
                        cnt_q <= CNT_W'(BIN_W);
                        ovf_q <= (64'(i_bin) > MAX_VAL);
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    acc_q <= acc_next;
                    bin_q <= bin_next;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    o_done     <= 1'b1;
                    o_overflow <= ovf_q;
                    o_bcd      <= ovf_q ? {DIGITS{4'h9}} : acc_q;
                    o_seg      <= seg_next;
                    state      <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decimal_display_seq.sv
// Scoreboard bench: two instances (blanking on / off) fed identical random and directed values.
// Expected results come from a decimal-arithmetic model; a monitor checks each o_done pulse.
// Timing of o_done, ignored i_valid while busy, and reset abort are also checked.
module tb_decimal_display_seq;

    localparam int DIGITS = 6;
    localparam int BIN_W  = 20;
    localparam int LAT    = BIN_W + 1;

    logic                  clk;
    logic                  i_reset;
    logic                  i_valid;
    logic [BIN_W-1:0]      i_bin;

    logic                  rdy_a, done_a, ovf_a;
    logic [DIGITS*4-1:0]   bcd_a;
    logic [DIGITS*7-1:0]   seg_a;
    logic                  rdy_b, done_b, ovf_b;
    logic [DIGITS*4-1:0]   bcd_b;
    logic [DIGITS*7-1:0]   seg_b;

    decimal_display_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W), .LZ_BLANK(1)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .i_bin(i_bin),
        .o_ready(rdy_a), .o_done(done_a), .o_overflow(ovf_a), .o_bcd(bcd_a), .o_seg(seg_a)
    );

    decimal_display_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W), .LZ_BLANK(0)) dut_nolz (
        .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .i_bin(i_bin),
        .o_ready(rdy_b), .o_done(done_b), .o_overflow(ovf_b), .o_bcd(bcd_b), .o_seg(seg_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] bcd;
        logic [41:0] seg_lz;
        logic [41:0] seg_nolz;
        logic        ovf;
        int          t_acc;
        int unsigned val;
    } exp_t;

    exp_t        sb[$];
    exp_t        last_e;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          n_done = 0;
    int          n_expect = 0;
    logic [6:0]  seg_tbl [10];

    initial begin
        seg_tbl[0] = 7'h40; seg_tbl[1] = 7'h79; seg_tbl[2] = 7'h24; seg_tbl[3] = 7'h30;
        seg_tbl[4] = 7'h19; seg_tbl[5] = 7'h12; seg_tbl[6] = 7'h02; seg_tbl[7] = 7'h78;
        seg_tbl[8] = 7'h00; seg_tbl[9] = 7'h10;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Decimal reference: digits by repeated division, blanking above the top nonzero digit
    function automatic exp_t model(input int unsigned v, input int t);
        exp_t        e;
        int unsigned r;
        int          d [DIGITS];
        int          msd;
        e.t_acc    = t;
        e.val      = v;
        e.ovf      = (v > 999999);
        e.bcd      = '0;
        e.seg_lz   = '0;
        e.seg_nolz = '0;
        if (e.ovf) begin
            e.bcd      = 24'h999999;
            e.seg_lz   = {6{7'h3F}};
            e.seg_nolz = {6{7'h3F}};
        end else begin
            r   = v;
            msd = 0;
            for (int k = 0; k < DIGITS; k++) begin
                d[k] = int'(r % 10);
                r    = r / 10;
                if (d[k] != 0) msd = k;
                e.bcd[k*4 +: 4] = 4'(d[k]);
            end
            for (int k = 0; k < DIGITS; k++) begin
                e.seg_nolz[k*7 +: 7] = seg_tbl[d[k]];
                e.seg_lz[k*7 +: 7]   = (k > msd) ? 7'h7F : seg_tbl[d[k]];
            end
        end
        return e;
    endfunction

    // Monitor: every o_done must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done_a === 1'b1) begin
            exp_t e;
            n_done++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk($sformatf("latency[%0d]", e.val), 64'(cyc - e.t_acc), 64'(LAT));
                chk($sformatf("bcd[%0d]", e.val), 64'(bcd_a), 64'(e.bcd));
                chk($sformatf("seg_lz[%0d]", e.val), 64'(seg_a), 64'(e.seg_lz));
                chk($sformatf("ovf[%0d]", e.val), 64'(ovf_a), 64'(e.ovf));
                chk($sformatf("done_nolz[%0d]", e.val), 64'(done_b), 64'd1);
                chk($sformatf("bcd_nolz[%0d]", e.val), 64'(bcd_b), 64'(e.bcd));
                chk($sformatf("seg_nolz[%0d]", e.val), 64'(seg_b), 64'(e.seg_nolz));
                chk($sformatf("ready_at_done[%0d]", e.val), 64'(rdy_a), 64'd1);
            end
        end
    end

    // Wait (bounded) for ready, present one value for one accepting edge, return accept cycle
    task automatic send(input int unsigned v, input bit expect_result, output int t);
        int n;
        exp_t e;
        n = 0;
        while (rdy_a !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (rdy_a !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL ready_timeout actual=%b required=1", rdy_a);
        end
        i_valid = 1'b1;
        i_bin   = BIN_W'(v);
        t       = cyc + 1;
        if (expect_result) begin
            e = model(v, t);
            sb.push_back(e);
            last_e = e;
            n_expect++;
        end
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    initial begin
        int t;
        int n;
        int unsigned v;
        int unsigned dir [6];
        dir[0] = 123456; dir[1] = 42; dir[2] = 0; dir[3] = 999999; dir[4] = 1000000; dir[5] = 1048575;

        i_reset = 1'b1;
        i_valid = 1'b1;
        i_bin   = 20'd7;
        repeat (2) @(posedge clk);
        #1;
        i_reset = 1'b0;
        i_valid = 1'b0;
        chk("reset_seg", 64'(seg_a), 64'({6{7'h7F}}));
        chk("reset_bcd", 64'(bcd_a), 64'd0);
        chk("reset_ready", 64'(rdy_a), 64'd1);
        chk("reset_done", 64'(done_a), 64'd0);
        chk("reset_ovf", 64'(ovf_a), 64'd0);

        foreach (dir[i]) send(dir[i], 1'b1, t);

        // Busy period: second i_valid ignored, outputs hold the previous result
        n = 0;
        while (rdy_a !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        send(777777, 1'b1, t);
        chk("busy_ready", 64'(rdy_a), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        i_valid = 1'b1;
        i_bin   = 20'd31;
        @(posedge clk); #1;
        i_valid = 1'b0;
        chk("ignored_valid_ready", 64'(rdy_a), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("hold_bcd", 64'(bcd_a), 64'(model(1048575, 0).bcd));
        chk("hold_seg", 64'(seg_a), 64'(model(1048575, 0).seg_lz));

        // Reset during conversion: abort, blank outputs, ready straight away, no o_done
        send(654321, 1'b0, t);
        repeat (8) @(posedge clk);
        #1;
        i_reset = 1'b1;
        i_valid = 1'b1;
        i_bin   = 20'd5;
        @(posedge clk); #1;
        i_reset = 1'b0;
        i_valid = 1'b0;
        chk("abort_ready", 64'(rdy_a), 64'd1);
        chk("abort_seg", 64'(seg_a), 64'({6{7'h7F}}));
        chk("abort_bcd", 64'(bcd_a), 64'd0);
        chk("abort_done", 64'(done_a), 64'd0);
        repeat (30) @(posedge clk);
        #1;

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       v = $urandom_range(0, 99);
                1:       v = $urandom_range(0, 999999);
                2:       v = $urandom_range(1000000, 1048575);
                default: v = $urandom_range(0, 1048575);
            endcase
            send(v, 1'b1, t);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        chk("done_count", 64'(n_done), 64'(n_expect));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
